// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver. Frame is start(0), 8 data bits LSB first,
// even parity, stop(1). Each bit is sampled at mid-bit with a clock counter.
// Ports:
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   RX_serial_in   asynchronous serial line, idles high
//   RX_data_out    last good byte, held until the next good frame
//   RX_valid       one-clk strobe on a frame with a good stop bit
//   RX_parity_err  parity mismatch of the last good frame (held)
//   RX_frame_err   one-clk strobe when the stop bit is sampled low
//   RX_active      high from start detection until the frame ends
module uart_rx #(
    parameter int unsigned BR               = 9600,
    parameter int unsigned CLK_RATE         = 50_000_000,
    parameter int unsigned POSEDGES_FOR_BIT = CLK_RATE / BR
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       RX_serial_in,
    output logic [7:0] RX_data_out,
    output logic       RX_valid,
    output logic       RX_parity_err,
    output logic       RX_frame_err,
    output logic       RX_active
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned DATA_W = 8;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(POSEDGES_FOR_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(POSEDGES_FOR_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                perr_q, perr_d;
    logic [DATA_W-1:0]   data_d;
    logic                valid_d;
    logic                parity_err_d;
    logic                frame_err_d;
    logic                active_d;
    logic                rx_meta;
    logic                rx_s;
    logic                bit_done;

    // Two-flop synchroniser; resets to the idle line level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX_serial_in;
            rx_s    <= rx_meta;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            perr_q        <= 1'b0;
            RX_data_out   <= '0;
            RX_valid      <= 1'b0;
            RX_parity_err <= 1'b0;
            RX_frame_err  <= 1'b0;
            RX_active     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            perr_q        <= perr_d;
            RX_data_out   <= data_d;
            RX_valid      <= valid_d;
            RX_parity_err <= parity_err_d;
            RX_frame_err  <= frame_err_d;
            RX_active     <= active_d;
        end
    end

    assign bit_done = (cnt_q == BIT_LAST);

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        perr_d       = perr_q;
        data_d       = RX_data_out;
        valid_d      = 1'b0;
        parity_err_d = RX_parity_err;
        frame_err_d  = 1'b0;
        active_d     = RX_active;

        case (state_q)
            IDLE: begin
                active_d = 1'b0;
                cnt_d    = '0;
                if (!rx_s) begin
                    state_d  = START;
                    active_d = 1'b1;
                end
            end

            // Half a bit in, the line must still be low or it was a glitch.
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    idx_d = '0;
                    if (!rx_s) begin
                        state_d = DATA;
                    end else begin
                        state_d  = IDLE;
                        active_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                if (bit_done) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == IDX_LAST) begin
                        state_d = PARITY;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            PARITY: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    perr_d  = rx_s ^ (^shift_q);
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Leaving at the stop mid-point lets a following start bit be seen.
            STOP: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d       = shift_q;
                        parity_err_d = perr_q;
                        valid_d      = 1'b1;
                        active_d     = 1'b0;
                        state_d      = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Hold off until the line returns high so a break is not decoded.
            BREAK: begin
                if (rx_s) begin
                    state_d  = IDLE;
                    active_d = 1'b0;
                end
            end

            default: begin
                state_d  = IDLE;
                cnt_d    = '0;
                active_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns / 1ps
module tb_uart_rx;

    localparam int unsigned BIT_CLKS = 16;

    typedef struct packed {
        logic       ferr;
        logic [7:0] data;
        logic       perr;
    } ev_t;

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       s;
        int         gap;
        logic       exp_ferr;
        logic [7:0] exp_data;
        logic       exp_perr;
    } vec_t;

    logic       clk;
    logic       reset_n;
    logic       rx;
    logic [7:0] RX_data_out;
    logic       RX_valid;
    logic       RX_parity_err;
    logic       RX_frame_err;
    logic       RX_active;

    int   n_checks;
    int   n_fail;
    int   n_overlap;
    int   rd_ptr;
    ev_t  got[$];
    ev_t  exp_q[$];

    logic [7:0] model_data;
    logic       model_perr;

    uart_rx #(.BR(1), .CLK_RATE(16)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .RX_serial_in  (rx),
        .RX_data_out   (RX_data_out),
        .RX_valid      (RX_valid),
        .RX_parity_err (RX_parity_err),
        .RX_frame_err  (RX_frame_err),
        .RX_active     (RX_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every strobe the receiver issues.
    always @(negedge clk) begin
        if (RX_valid && RX_frame_err) n_overlap <= n_overlap + 1;
        if (RX_valid || RX_frame_err)
            got.push_back('{ferr: RX_frame_err && !RX_valid, data: RX_data_out, perr: RX_parity_err});
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_bit(input string name, input logic act, input logic req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    task automatic drive_bit(input logic b);
        @(posedge clk);
        #1 rx = b;
        repeat (8) @(posedge clk);
        #1 check_bit("active_in_frame", RX_active, 1'b1);
        repeat (7) @(posedge clk);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1 rx = 1'b1;
            repeat (BIT_CLKS - 1) @(posedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(s);
    endtask

    // Reference: a good stop yields the byte and its even-parity verdict;
    // a bad stop yields a framing strobe with the previous outputs held.
    task automatic model_frame(input logic [7:0] d, input logic p, input logic s);
        if (s) begin
            model_data = d;
            model_perr = p ^ (^d);
            exp_q.push_back('{ferr: 1'b0, data: model_data, perr: model_perr});
        end else begin
            exp_q.push_back('{ferr: 1'b1, data: model_data, perr: model_perr});
        end
    endtask

    task automatic check_events(input string name);
        int t;
        ev_t g;
        t = 0;
        while ((got.size() - rd_ptr) < exp_q.size() && t < 400) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if ((got.size() - rd_ptr) < exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d strobes expected %0d", name,
                     got.size() - rd_ptr, exp_q.size());
            rd_ptr = got.size();
        end else begin
            foreach (exp_q[i]) begin
                g = got[rd_ptr];
                rd_ptr++;
                n_checks++;
                if (g !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL %s: got ferr=%b data=%h perr=%b expected ferr=%b data=%h perr=%b",
                             name, g.ferr, g.data, g.perr, exp_q[i].ferr, exp_q[i].data, exp_q[i].perr);
                end
            end
        end
        n_checks++;
        if (got.size() != rd_ptr) begin
            n_fail++;
            $display("FAIL %s_extra: got %0d extra strobes expected 0", name, got.size() - rd_ptr);
            rd_ptr = got.size();
        end
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if (RX_data_out !== 8'h00 || RX_valid !== 1'b0 || RX_parity_err !== 1'b0 ||
            RX_frame_err !== 1'b0 || RX_active !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got data=%h v=%b pe=%b fe=%b act=%b expected all 0", name,
                     RX_data_out, RX_valid, RX_parity_err, RX_frame_err, RX_active);
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        idle_bits(v.gap);
        send_frame(v.d, v.p, v.s);
        exp_q.push_back('{ferr: v.exp_ferr, data: v.exp_data, perr: v.exp_perr});
        check_events(name);
    endtask

    vec_t vecs[6];
    logic [7:0] rd;
    logic       rp, rs, prev_bad;
    int         rgap;
    logic [7:0] pre_byte;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        n_overlap = 0;
        rd_ptr    = 0;
        model_data = 8'h00;
        model_perr = 1'b0;

        vecs[0] = '{d: 8'hA5, p: 1'b0, s: 1'b1, gap: 2, exp_ferr: 1'b0, exp_data: 8'hA5, exp_perr: 1'b0};
        vecs[1] = '{d: 8'h01, p: 1'b0, s: 1'b1, gap: 2, exp_ferr: 1'b0, exp_data: 8'h01, exp_perr: 1'b1};
        vecs[2] = '{d: 8'h03, p: 1'b0, s: 1'b1, gap: 2, exp_ferr: 1'b0, exp_data: 8'h03, exp_perr: 1'b0};
        vecs[3] = '{d: 8'h55, p: 1'b0, s: 1'b1, gap: 2, exp_ferr: 1'b0, exp_data: 8'h55, exp_perr: 1'b0};
        vecs[4] = '{d: 8'h12, p: 1'b0, s: 1'b1, gap: 2, exp_ferr: 1'b0, exp_data: 8'h12, exp_perr: 1'b0};
        vecs[5] = '{d: 8'hFF, p: 1'b0, s: 1'b1, gap: 0, exp_ferr: 1'b0, exp_data: 8'hFF, exp_perr: 1'b0};

        rx      = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        @(posedge clk);
        #1 reset_n = 1'b1;
        idle_bits(1);
        check_reset_outputs("post_reset_idle");

        for (int i = 0; i < 3; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Bad stop bit followed by a 20-bit break.
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (20 * BIT_CLKS) @(posedge clk);
        #1;
        n_checks++;
        if ((got.size() - rd_ptr) != 1) begin
            n_fail++;
            $display("FAIL break_strobes: got %0d expected 1", got.size() - rd_ptr);
        end
        rx = 1'b1;
        repeat (20) @(posedge clk);
        #1 check_bit("break_release_active", RX_active, 1'b0);
        exp_q.push_back('{ferr: 1'b1, data: 8'h03, perr: 1'b0});
        check_events("break");
        check_bit("break_data_held", RX_data_out == 8'h03, 1'b1);

        // 3-clk glitch on an idle line.
        idle_bits(2);
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx = 1'b1;
        repeat (30) @(posedge clk);
        #1 check_bit("glitch_active", RX_active, 1'b0);
        check_events("glitch");

        // 0x55, then 0x12 and 0xFF back-to-back.
        for (int i = 3; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset asserted during data bit 4.
        idle_bits(2);
        pre_byte = 8'hC3;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(pre_byte[i]);
        @(posedge clk);
        #1 rx = pre_byte[4];
        repeat (8) @(posedge clk);
        #1 reset_n = 1'b0;
        #1 check_reset_outputs("reset_mid_frame");
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1 reset_n = 1'b1;
        idle_bits(2);
        check_events("reset_no_strobe");
        model_data = 8'h00;
        model_perr = 1'b0;
        send_frame(8'h81, 1'b0, 1'b1);
        exp_q.push_back('{ferr: 1'b0, data: 8'h81, perr: 1'b0});
        check_events("after_reset_81");
        model_data = 8'h81;
        model_perr = 1'b0;

        // Randomised frames against the reference model.
        prev_bad = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rd   = 8'($urandom);
            rp   = 1'($urandom_range(0, 1));
            rs   = ($urandom_range(0, 7) != 0);
            rgap = prev_bad ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 2));
            idle_bits(rgap);
            send_frame(rd, rp, rs);
            model_frame(rd, rp, rs);
            check_events($sformatf("rand%0d", i));
            prev_bad = !rs;
        end
        idle_bits(2);
        check_bit("final_active", RX_active, 1'b0);

        n_checks++;
        if (n_overlap != 0) begin
            n_fail++;
            $display("FAIL strobe_overlap: got %0d cycles expected 0", n_overlap);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
